// File: rtl/btn_cond_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// Auto-repeat is enabled by defining BTN_COND_AUTOREPEAT_EN.
package btn_cond_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESS_PEND,
      ST_PRESSED,
      ST_REL_PEND
   } btn_state_t;

   localparam int BTN_DEBOUNCE_DEFAULT      = 250000;   // 10 ms at 25 MHz
   localparam int BTN_REPEAT_DELAY_DEFAULT  = 12500000;
   localparam int BTN_REPEAT_PERIOD_DEFAULT = 2500000;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM and, with BTN_COND_AUTOREPEAT_EN,
// a repeat counter that re-pulses press while the button stays down.
module btn_debounce_ch
   import btn_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
   parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEFAULT,
   parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic press,
   output logic rel
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("btn_debounce_ch: illegal parameter set");
   end

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   btn_state_t             state;
   logic [CW-1:0]          cnt;
   logic                   held;
   logic                   rpt_hit;

   assign s    = sync[SYNC_STAGES-1];
   assign held = (state == ST_PRESSED) || (state == ST_REL_PEND);

`ifdef BTN_COND_AUTOREPEAT_EN
   localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rpt_cnt;
   logic          rpt_first;

   assign rpt_hit = held && (rpt_cnt == (rpt_first ? DLY_LAST : PER_LAST));

   // Sits cleared outside PRESSED/REL_PEND, so it starts from zero on the commit.
   always_ff @(posedge clk) begin
      if (rst || !held) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else if (rpt_hit) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b0;
      end else begin
         rpt_cnt   <= rpt_cnt + 1'b1;
      end
   end
`else
   assign rpt_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         state <= ST_RELEASED;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], pin};
         press <= rpt_hit;
         rel   <= 1'b0;
         unique case (state)
            ST_RELEASED:
               if (s) begin
                  state <= ST_PRESS_PEND;
                  cnt   <= CNT_ONE;
               end
            ST_PRESS_PEND:
               if (!s) begin
                  state <= ST_RELEASED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_PRESSED;
                  cnt   <= '0;
                  level <= 1'b1;
                  press <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
               end
            ST_PRESSED:
               if (!s) begin
                  state <= ST_REL_PEND;
                  cnt   <= CNT_ONE;
               end
            ST_REL_PEND:
               if (s) begin
                  state <= ST_PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  // release wins over a repeat landing on the same edge
                  state <= ST_RELEASED;
                  cnt   <= '0;
                  level <= 1'b0;
                  press <= 1'b0;
                  rel   <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
               end
            default: begin
               state <= ST_RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: polarity normalise, synchronise and debounce N_BTN pins.
// Optional auto-repeat on o_press is enabled by defining BTN_COND_AUTOREPEAT_EN.
module btn_conditioner
   import btn_cond_pkg::*;
#(
   parameter int               N_BTN           = 7,
   parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = 7'b0000001,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
   parameter int               REPEAT_DELAY    = BTN_REPEAT_DELAY_DEFAULT,
   parameter int               REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] o_level,
   output logic [N_BTN-1:0] o_press,
   output logic [N_BTN-1:0] o_release
);

   logic [N_BTN-1:0] pin;

   // After this, 1 means pressed on every channel.
   assign pin = btn ^ ACTIVE_LOW_MASK;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clk  (i_clk),
         .rst  (i_rst),
         .pin  (pin[i]),
         .level(o_level[i]),
         .press(o_press[i]),
         .rel  (o_release[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed vector table, hand-written corner sequences
// and a randomized phase scored against a run-length reference model.
module tb_btn_conditioner;

   localparam int N    = 7;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int RDLY = 10;
   localparam int RPER = 3;
   localparam logic [N-1:0] MASK = 7'b0000001;
`ifdef BTN_COND_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn = 7'b0000001;
   logic [N-1:0] lvl, prs, rel;

   btn_conditioner #(
      .N_BTN(N), .ACTIVE_LOW_MASK(MASK), .SYNC_STAGES(SYNC),
      .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
   ) dut (
      .i_clk(clk), .i_rst(rst), .btn(btn),
      .o_level(lvl), .o_press(prs), .o_release(rel)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit sb_en = 1'b0;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: input delayed SYNC cycles; a level flips once the delayed
   // input has disagreed with it for DEB consecutive cycles.
   logic [N-1:0] m_pipe [SYNC];
   logic [N-1:0] m_lvl, m_prs, m_rel;
   int           m_run [N];
   int           m_age [N];

   task automatic model_step();
      logic [N-1:0] s;
      if (rst) begin
         for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
         m_lvl = '0; m_prs = '0; m_rel = '0;
         for (int c = 0; c < N; c++) begin m_run[c] = 0; m_age[c] = 0; end
      end else begin
         s = m_pipe[SYNC-1];
         for (int k = SYNC-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
         m_pipe[0] = btn ^ MASK;
         m_prs = '0; m_rel = '0;
         for (int c = 0; c < N; c++) begin
            if (s[c] != m_lvl[c]) begin
               m_run[c]++;
               if (m_run[c] == DEB) begin
                  m_run[c] = 0;
                  m_lvl[c] = s[c];
                  if (s[c]) begin m_prs[c] = 1'b1; m_age[c] = 0; end
                  else m_rel[c] = 1'b1;
               end
            end else begin
               m_run[c] = 0;
            end
            if (AR && m_lvl[c] && !m_prs[c]) begin
               m_age[c]++;
               if (m_age[c] >= RDLY && (m_age[c] - RDLY) % RPER == 0) m_prs[c] = 1'b1;
            end
         end
      end
   endtask

   initial begin : scoreboard
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (sb_en) begin
            check("sb_level", lvl, m_lvl);
            check("sb_press", prs, m_prs);
            check("sb_release", rel, m_rel);
            check("sb_excl", prs & rel, '0);
         end
      end
   end

   typedef struct {
      logic [N-1:0] b;
      logic [N-1:0] l;
      logic [N-1:0] p;
      logic [N-1:0] r;
   } vec_t;
   vec_t vq[$];

   task automatic add(input logic [N-1:0] b, l, p, r, input int n);
      vec_t v;
      v.b = b; v.l = l; v.p = p; v.r = r;
      repeat (n) vq.push_back(v);
   endtask

   int hold [N];
   bit exp1;

   initial begin
      // Each entry: drive b, let one rising edge pass, then expect l/p/r.
      add(7'b0000011, 7'b0000000, 7'b0000000, 7'b0000000, 5);  // clean press btn1
      add(7'b0000011, 7'b0000010, 7'b0000010, 7'b0000000, 1);
      add(7'b0000011, 7'b0000010, 7'b0000000, 7'b0000000, 1);
      add(7'b0000001, 7'b0000010, 7'b0000000, 7'b0000000, 5);
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b0000010, 1);
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 1);
      add(7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 5);  // active-low btn0
      add(7'b0000000, 7'b0000001, 7'b0000001, 7'b0000000, 1);
      add(7'b0000000, 7'b0000001, 7'b0000000, 7'b0000000, 1);
      add(7'b0000001, 7'b0000001, 7'b0000000, 7'b0000000, 5);
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b0000001, 1);
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 1);
      add(7'b1001001, 7'b0000000, 7'b0000000, 7'b0000000, 5);  // btn3 + btn6 together
      add(7'b1001001, 7'b1001000, 7'b1001000, 7'b0000000, 1);
      add(7'b1001001, 7'b1001000, 7'b0000000, 7'b0000000, 1);
      add(7'b0000001, 7'b1001000, 7'b0000000, 7'b0000000, 5);
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b1001000, 1);
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 1);
      add(7'b0000101, 7'b0000000, 7'b0000000, 7'b0000000, 1);  // btn2 bounce
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 1);
      add(7'b0000101, 7'b0000000, 7'b0000000, 7'b0000000, 1);
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 1);
      add(7'b0000101, 7'b0000000, 7'b0000000, 7'b0000000, 5);
      add(7'b0000101, 7'b0000100, 7'b0000100, 7'b0000000, 1);
      add(7'b0000101, 7'b0000100, 7'b0000000, 7'b0000000, 1);
      add(7'b0000001, 7'b0000100, 7'b0000000, 7'b0000000, 5);
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b0000100, 1);
      add(7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 1);

      rst = 1'b1;
      btn = 7'b0000001;
      repeat (3) @(negedge clk);
      sb_en = 1'b1;
      check("rst_level", lvl, '0);
      check("rst_press", prs, '0);
      check("rst_release", rel, '0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("idle_level", lvl, '0);

      for (int i = 0; i < vq.size(); i++) begin
         btn = vq[i].b;
         @(negedge clk);
         check($sformatf("tbl%0d_level", i), lvl, vq[i].l);
         check($sformatf("tbl%0d_press", i), prs, vq[i].p);
         check($sformatf("tbl%0d_release", i), rel, vq[i].r);
      end

      // Reset while btn4 is still qualifying: exactly one press afterwards.
      btn = 7'b0010001;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_level", lvl, '0);
      check("midrst_press", prs, '0);
      check("midrst_release", rel, '0);
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp1 = (k == 6);
         check($sformatf("midrst_press4_k%0d", k), {6'b0, prs[4]}, {6'b0, exp1});
      end
      btn = 7'b0000001;
      repeat (8) @(negedge clk);

      // Long hold on btn5: commit pulse, then repeats only when enabled.
      btn = 7'b0100001;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         exp1 = (k == 6) || (AR && k >= 6 + RDLY && (k - 6 - RDLY) % RPER == 0);
         check($sformatf("rpt_press5_k%0d", k), {6'b0, prs[5]}, {6'b0, exp1});
      end
      btn = 7'b0000001;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp1 = AR && (k < 6) && ((30 + k - 6 - RDLY) % RPER == 0);
         check($sformatf("rel_press5_k%0d", k), {6'b0, prs[5]}, {6'b0, exp1});
         exp1 = (k == 6);
         check($sformatf("rel_release5_k%0d", k), {6'b0, rel[5]}, {6'b0, exp1});
      end

      // Randomized phase: the scoreboard checks every cycle.
      for (int c = 0; c < N; c++) hold[c] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < N; c++) begin
            if (hold[c] == 0) begin
               btn[c] = 1'($urandom % 2);
               case ($urandom % 3)
                  0:       hold[c] = int'($urandom_range(3, 1));
                  1:       hold[c] = int'($urandom_range(12, 4));
                  default: hold[c] = int'($urandom_range(30, 13));
               endcase
            end else begin
               hold[c]--;
            end
         end
         rst = ($urandom_range(399, 0) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
